// File: rtl/logic_axi4_stream_packer_pkg.sv
// Shared types and helpers for the AXI4-Stream null-byte packer.
// Functions take a fixed maximum width; callers size-cast to their bus width.
package logic_axi4_stream_packer_pkg;

  typedef logic [7:0] byte_t;

  localparam int MAX_BYTES = 64;

  typedef enum logic [1:0] {
    EMIT_NONE,
    EMIT_FULL,
    EMIT_TAIL
  } emit_kind_e;

  // Width of the accumulator fill counter (holds 0..2N-1).
  function automatic int count_width(input int n);
    return $clog2(2 * n);
  endfunction

  function automatic int popcount(input logic [MAX_BYTES-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      c += int'(v[i]);
    end
    return c;
  endfunction

  function automatic logic [MAX_BYTES-1:0] keep_mask(input int n);
    logic [MAX_BYTES-1:0] m;
    for (int i = 0; i < MAX_BYTES; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/logic_axi4_stream_packer_compact.sv
// Squeezes the kept bytes of one beat down to the LSB end and counts them.
// Purely combinational; unkept output lanes are zero.
module logic_axi4_stream_packer_compact
  import logic_axi4_stream_packer_pkg::*;
#(
  parameter int N  = 4,
  parameter int KW = $clog2(N + 1)
) (
  input  logic [N-1:0][7:0] tdata,
  input  logic [N-1:0]      tstrb,
  input  logic [N-1:0]      tkeep,
  output logic [N-1:0][7:0] data,
  output logic [N-1:0]      strb,
  output logic [KW-1:0]     k
);

  int pos;

  always_comb begin
    data = '0;
    strb = '0;
    pos  = 0;
    // Each kept input byte lands at the number of kept bytes below it.
    for (int i = 0; i < N; i++) begin
      if (tkeep[i]) begin
        for (int j = 0; j < N; j++) begin
          if (j == pos) begin
            data[j] = tdata[i];
            strb[j] = tstrb[i];
          end
        end
        pos = pos + 1;
      end
    end
    k = KW'(popcount(MAX_BYTES'(tkeep)));
  end

endmodule

// File: rtl/logic_axi4_stream_packer.sv
// AXI4-Stream packer: drops null bytes and emits full beats, with only the
// final beat of a packet partially filled (contiguous tkeep from bit 0).
module logic_axi4_stream_packer
  import logic_axi4_stream_packer_pkg::*;
#(
  parameter int TDATA_BYTES = 4,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            rx_tvalid,
  output logic                            rx_tready,
  input  logic                            rx_tlast,
  input  logic [TDATA_BYTES-1:0][7:0]     rx_tdata,
  input  logic [TDATA_BYTES-1:0]          rx_tkeep,
  input  logic [TDATA_BYTES-1:0]          rx_tstrb,
  input  logic [TDEST_WIDTH-1:0]          rx_tdest,
  input  logic [TUSER_WIDTH-1:0]          rx_tuser,
  input  logic [TID_WIDTH-1:0]            rx_tid,
  output logic                            tx_tvalid,
  input  logic                            tx_tready,
  output logic                            tx_tlast,
  output logic [TDATA_BYTES-1:0][7:0]     tx_tdata,
  output logic [TDATA_BYTES-1:0]          tx_tkeep,
  output logic [TDATA_BYTES-1:0]          tx_tstrb,
  output logic [TDEST_WIDTH-1:0]          tx_tdest,
  output logic [TUSER_WIDTH-1:0]          tx_tuser,
  output logic [TID_WIDTH-1:0]            tx_tid
);

  localparam int N  = TDATA_BYTES;
  localparam int CW = count_width(N);
  localparam int KW = $clog2(N + 1);

  byte_t [2*N-1:0]        acc_data_reg, acc_data_next;
  logic  [2*N-1:0]        acc_strb_reg, acc_strb_next;
  logic  [CW-1:0]         count_reg, count_next;
  logic                   last_pending_reg, last_pending_next;
  logic                   sideband_valid_reg, sideband_valid_next;
  logic [TDEST_WIDTH-1:0] dest_reg, dest_next;
  logic [TUSER_WIDTH-1:0] user_reg, user_next;
  logic [TID_WIDTH-1:0]   id_reg, id_next;

  byte_t [N-1:0] comp_data;
  logic  [N-1:0] comp_strb;
  logic [KW-1:0] comp_k;

  emit_kind_e emit_kind;
  int         count_int;
  int         emit_n;
  int         emitted;
  int         count_after;
  int         k_in;
  logic       fire;
  logic       accept;

  logic_axi4_stream_packer_compact #(
    .N  (N),
    .KW (KW)
  ) u_compact (
    .tdata (rx_tdata),
    .tstrb (rx_tstrb),
    .tkeep (rx_tkeep),
    .data  (comp_data),
    .strb  (comp_strb),
    .k     (comp_k)
  );

  assign count_int = int'(count_reg);

  // Emission choice depends only on registered state.
  always_comb begin
    emit_kind = EMIT_NONE;
    emit_n    = 0;
    if (count_int > N) begin
      emit_kind = EMIT_FULL;
      emit_n    = N;
    end else if (last_pending_reg) begin
      emit_kind = EMIT_TAIL;
      emit_n    = count_int;
    end else if (count_int == N) begin
      emit_kind = EMIT_FULL;
      emit_n    = N;
    end
  end

  assign tx_tvalid = (emit_kind != EMIT_NONE);
  assign tx_tlast  = (emit_kind == EMIT_TAIL);
  assign tx_tkeep  = N'(keep_mask(emit_n));
  assign tx_tdest  = dest_reg;
  assign tx_tuser  = user_reg;
  assign tx_tid    = id_reg;

  for (genvar gi = 0; gi < N; gi++) begin : g_tx_lane
    assign tx_tdata[gi] = tx_tkeep[gi] ? acc_data_reg[gi] : 8'h00;
    assign tx_tstrb[gi] = tx_tkeep[gi] & acc_strb_reg[gi];
  end

  assign fire   = tx_tvalid & tx_tready;
  // Accepting while count >= N is only safe when a full beat drains this cycle.
  assign rx_tready = !last_pending_reg & ((count_int < N) | (fire & !tx_tlast));
  assign accept = rx_tvalid & rx_tready;

  always_comb begin
    emitted       = fire ? emit_n : 0;
    count_after   = count_int - emitted;
    k_in          = accept ? int'(comp_k) : 0;
    acc_data_next = '0;
    acc_strb_next = '0;
    // Shift out the emitted bytes, then append the compacted beat behind the rest.
    for (int d = 0; d < 2*N; d++) begin
      for (int s = 0; s < 2*N; s++) begin
        if (s == d + emitted) begin
          acc_data_next[d] = acc_data_reg[s];
          acc_strb_next[d] = acc_strb_reg[s];
        end
      end
      for (int j = 0; j < N; j++) begin
        if ((j < k_in) && (d == count_after + j)) begin
          acc_data_next[d] = comp_data[j];
          acc_strb_next[d] = comp_strb[j];
        end
      end
    end
    count_next = CW'(count_after + k_in);

    last_pending_next   = last_pending_reg;
    sideband_valid_next = sideband_valid_reg;
    dest_next           = dest_reg;
    user_next           = user_reg;
    id_next             = id_reg;
    if (fire && tx_tlast) begin
      last_pending_next   = 1'b0;
      sideband_valid_next = 1'b0;
    end
    if (accept) begin
      if (rx_tlast) begin
        last_pending_next = 1'b1;
      end
      if (!sideband_valid_reg) begin
        sideband_valid_next = 1'b1;
        dest_next           = rx_tdest;
        user_next           = rx_tuser;
        id_next             = rx_tid;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      acc_data_reg       <= '0;
      acc_strb_reg       <= '0;
      count_reg          <= '0;
      last_pending_reg   <= 1'b0;
      sideband_valid_reg <= 1'b0;
      dest_reg           <= '0;
      user_reg           <= '0;
      id_reg             <= '0;
    end else begin
      acc_data_reg       <= acc_data_next;
      acc_strb_reg       <= acc_strb_next;
      count_reg          <= count_next;
      last_pending_reg   <= last_pending_next;
      sideband_valid_reg <= sideband_valid_next;
      dest_reg           <= dest_next;
      user_reg           <= user_next;
      id_reg             <= id_next;
    end
  end

endmodule
